// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two request ports, one response port and the
// link to the shared combinational ALU.
//
// Handshake: every valid/ready pair transfers on a rising clk edge where both
// are high. A source that raises valid keeps it and its payload stable until
// that transfer. ready may depend combinationally on valid. valid must never
// depend on ready.
interface alu_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [XLEN-1:0]   req0_a;
    logic [XLEN-1:0]   req0_b;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [XLEN-1:0]   req1_a;
    logic [XLEN-1:0]   req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [XLEN-1:0]   resp_result;
    logic              resp_zero;
    logic              resp_illegal;

    logic [XLEN-1:0]   alu_operand_a;
    logic [XLEN-1:0]   alu_operand_b;
    logic [CTRL_W-1:0] alu_control;
    logic [XLEN-1:0]   alu_result;
    logic              alu_zero;

    // Arbiter side of the bundle
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_illegal,
        input  resp_ready,
        output alu_operand_a, alu_operand_b, alu_control,
        input  alu_result, alu_zero
    );

    // Environment side: requesters, response consumer and the ALU
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_illegal,
        output resp_ready,
        input  alu_operand_a, alu_operand_b, alu_control,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The winning request drives the ALU this cycle; the ALU output is captured
// into a one-entry response register tagged with the requester id.
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);
    // Highest defined ALU code (AND); anything above it is illegal.
    localparam logic [CTRL_W-1:0] LAST_OP = CTRL_W'(9);

    logic              last_grant;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic [XLEN-1:0]   resp_result_q;
    logic              resp_zero_q;
    logic              resp_illegal_q;

    logic              grant0;
    logic              grant1;
    logic              slot_free;
    logic              xfer0;
    logic              xfer1;
    logic [XLEN-1:0]   sel_a;
    logic [XLEN-1:0]   sel_b;
    logic [CTRL_W-1:0] sel_ctrl;
    logic              sel_illegal;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    // The response slot can accept when empty or being drained this cycle.
    assign slot_free = !resp_valid_q || bus.resp_ready;

    assign bus.req0_ready = grant0 && slot_free;
    assign bus.req1_ready = grant1 && slot_free;

    assign xfer0 = bus.req0_valid && bus.req0_ready;
    assign xfer1 = bus.req1_valid && bus.req1_ready;

    // Steer the granted request onto the ALU, zeros when nobody is granted.
    // The grant alone selects, so the ALU sees the operation even while the
    // response slot is stalled.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        if (grant0) begin
            sel_a    = bus.req0_a;
            sel_b    = bus.req0_b;
            sel_ctrl = bus.req0_ctrl;
        end else if (grant1) begin
            sel_a    = bus.req1_a;
            sel_b    = bus.req1_b;
            sel_ctrl = bus.req1_ctrl;
        end
    end

    assign sel_illegal = sel_ctrl > LAST_OP;

    assign bus.alu_operand_a = sel_a;
    assign bus.alu_operand_b = sel_b;
    assign bus.alu_control   = sel_ctrl;

    // Response register and round-robin pointer. A transfer overwrites the
    // slot (even while it is being drained); a drain alone only clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_result_q  <= '0;
            resp_zero_q    <= 1'b0;
            resp_illegal_q <= 1'b0;
        end else if (xfer0 || xfer1) begin
            last_grant     <= xfer1;
            resp_valid_q   <= 1'b1;
            resp_id_q      <= xfer1;
            resp_illegal_q <= sel_illegal;
            resp_result_q  <= sel_illegal ? '0 : bus.alu_result;
            resp_zero_q    <= sel_illegal ? 1'b0 : bus.alu_zero;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q   <= 1'b0;
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_result  = resp_result_q;
    assign bus.resp_zero    = resp_zero_q;
    assign bus.resp_illegal = resp_illegal_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of per-cycle vectors followed by
// hand-written backpressure and reset-during-response sequences.
module tb_alu_arbiter;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_arbiter_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    alu_arbiter #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU standing in for the shared combinational unit. Undefined
    // codes produce a deliberately non-trivial value that must be discarded.
    always_comb begin
        bus.alu_result = bus.alu_operand_a ^ bus.alu_operand_b ^ 32'hDEADBEEF;
        case (bus.alu_control)
            4'd0: bus.alu_result = bus.alu_operand_a + bus.alu_operand_b;
            4'd1: bus.alu_result = bus.alu_operand_a - bus.alu_operand_b;
            4'd2: bus.alu_result = bus.alu_operand_a << bus.alu_operand_b[4:0];
            4'd3: bus.alu_result = {31'b0, $signed(bus.alu_operand_a) < $signed(bus.alu_operand_b)};
            4'd4: bus.alu_result = {31'b0, bus.alu_operand_a < bus.alu_operand_b};
            4'd5: bus.alu_result = bus.alu_operand_a ^ bus.alu_operand_b;
            4'd6: bus.alu_result = bus.alu_operand_a >> bus.alu_operand_b[4:0];
            4'd7: bus.alu_result = $unsigned($signed(bus.alu_operand_a) >>> bus.alu_operand_b[4:0]);
            4'd8: bus.alu_result = bus.alu_operand_a | bus.alu_operand_b;
            4'd9: bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
            default: ;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  c0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  c1;
        logic        rr;
        logic        e_r0;
        logic        e_r1;
        logic        e_rv;
        logic        e_id;
        logic [31:0] e_res;
        logic        e_z;
        logic        e_ill;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [3:0] c0, input logic v1, input logic [31:0] a1,
                           input logic [31:0] b1, input logic [3:0] c1, input logic rr,
                           input logic e_r0, input logic e_r1, input logic e_rv,
                           input logic e_id, input logic [31:0] e_res, input logic e_z,
                           input logic e_ill);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.rr = rr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_id = e_id;
        v.e_res = e_res; v.e_z = e_z; v.e_ill = e_ill;
        tbl.push_back(v);
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
    endtask

    task automatic chk_resp(input string tag, input logic rv, input logic id,
                            input logic [31:0] res, input logic z, input logic ill);
        chk({tag, "_resp_valid"},   bus.resp_valid,   rv);
        chk({tag, "_resp_id"},      bus.resp_id,      id);
        chk({tag, "_resp_result"},  bus.resp_result,  res);
        chk({tag, "_resp_zero"},    bus.resp_zero,    z);
        chk({tag, "_resp_illegal"}, bus.resp_illegal, ill);
    endtask

    // Inputs go on 1 time unit after a rising edge; readies are checked 1 unit
    // later, the response 1 unit after the following rising edge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive0(v.v0, v.a0, v.b0, v.c0);
        drive1(v.v1, v.a1, v.b1, v.c1);
        bus.resp_ready = v.rr;
        #1;
        chk({tag, "_req0_ready"}, bus.req0_ready, v.e_r0);
        chk({tag, "_req1_ready"}, bus.req1_ready, v.e_r1);
        @(posedge clk); #1;
        chk_resp(tag, v.e_rv, v.e_id, v.e_res, v.e_z, v.e_ill);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        bus.resp_ready = 1'b0;

        //       v0 a0            b0            c0    v1 a1            b1            c1    rr  r0 r1 rv id res           z  ill
        // single request: ADD 15+10
        add_vec(1, 32'd15,       32'd10,       4'd0, 0, 32'd0,        32'd0,        4'd0, 1,  1, 0, 1, 0, 32'd25,       0, 0);
        // requester 1 alone: SRA 80000000 >>> 31
        add_vec(0, 32'd0,        32'd0,        4'd0, 1, 32'h80000000, 32'd31,       4'd7, 1,  0, 1, 1, 1, 32'hFFFFFFFF, 0, 0);
        // round robin: SUB 5-5 vs XOR, alternating 0,1,0,1
        add_vec(1, 32'd5,        32'd5,        4'd1, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5, 1,  1, 0, 1, 0, 32'd0,        1, 0);
        add_vec(1, 32'd5,        32'd5,        4'd1, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5, 1,  0, 1, 1, 1, 32'hFFFFFFFF, 0, 0);
        add_vec(1, 32'd5,        32'd5,        4'd1, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5, 1,  1, 0, 1, 0, 32'd0,        1, 0);
        add_vec(1, 32'd5,        32'd5,        4'd1, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5, 1,  0, 1, 1, 1, 32'hFFFFFFFF, 0, 0);
        // illegal code 1100 from requester 1
        add_vec(0, 32'd0,        32'd0,        4'd0, 1, 32'd3,        32'd4,        4'hC, 1,  0, 1, 1, 1, 32'd0,        0, 1);
        // illegal 1111 where the ALU happens to report zero: flag must stay 0
        add_vec(1, 32'hDEADBEEF, 32'd0,        4'hF, 0, 32'd0,        32'd0,        4'd0, 1,  1, 0, 1, 0, 32'd0,        0, 1);
        // first illegal code 1010
        add_vec(0, 32'd0,        32'd0,        4'd0, 1, 32'd1,        32'd1,        4'hA, 1,  0, 1, 1, 1, 32'd0,        0, 1);
        // last legal code 1001 AND
        add_vec(1, 32'h0000FF00, 32'h00000F0F, 4'd9, 0, 32'd0,        32'd0,        4'd0, 1,  1, 0, 1, 0, 32'h00000F00, 0, 0);
        // idle with resp_ready: drain, other fields hold
        add_vec(0, 32'd0,        32'd0,        4'd0, 0, 32'd0,        32'd0,        4'd0, 1,  0, 0, 0, 0, 32'h00000F00, 0, 0);
        // idle without resp_ready: stays empty
        add_vec(0, 32'd0,        32'd0,        4'd0, 0, 32'd0,        32'd0,        4'd0, 0,  0, 0, 0, 0, 32'h00000F00, 0, 0);

        // Reset state and combinational readies while held in reset
        #12;
        chk_resp("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive0(1'b1, 32'd0, 32'd0, 4'd0);
        drive1(1'b1, 32'd0, 32'd0, 4'd0);
        #1;
        chk("reset_tie_req0_ready", bus.req0_ready, 1'b1);
        chk("reset_tie_req1_ready", bus.req1_ready, 1'b0);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk("reset_solo_req1_ready", bus.req1_ready, 1'b1);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // No grant: ALU sees all zeros
        chk("idle_alu_a",    bus.alu_operand_a, 32'd0);
        chk("idle_alu_b",    bus.alu_operand_b, 32'd0);
        chk("idle_alu_ctrl", bus.alu_control,   32'd0);

        // Backpressure: one transfer, then stall three cycles with both valid
        drive0(1'b1, 32'd1, 32'd2, 4'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk_resp("bp_first", 1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
        drive0(1'b1, 32'd5, 32'd5, 4'd1);
        drive1(1'b1, 32'h10, 32'h01, 4'd8);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall%0d_req0_ready", i), bus.req0_ready, 1'b0);
            chk($sformatf("bp_stall%0d_req1_ready", i), bus.req1_ready, 1'b0);
            @(posedge clk); #1;
            chk_resp($sformatf("bp_stall%0d", i), 1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
        end
        // Drain and accept in the same cycle; requester 1 is next in turn
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", bus.req0_ready, 1'b0);
        chk("bp_release_req1_ready", bus.req1_ready, 1'b1);
        chk("bp_release_alu_ctrl",   bus.alu_control, 32'd8);
        @(posedge clk); #1;
        chk_resp("bp_release", 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);

        // Reset while a response is pending and stalled
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        chk_resp("pre_reset", 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_resp("async_reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive0(1'b1, 32'd7, 32'd8, 4'd0);
        drive1(1'b1, 32'h10, 32'h01, 4'd8);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_req0_ready", bus.req0_ready, 1'b1);
        chk("post_reset_req1_ready", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        chk_resp("post_reset", 1'b1, 1'b0, 32'd15, 1'b0, 1'b0);
        // Second tie after reset goes to requester 1
        #1;
        chk("post_reset_rr_req1_ready", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        chk_resp("post_reset_rr", 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single combinational `alu` between independent producers, for example the execute stage and the branch/address unit. Each requester uses a valid/ready handshake. The block picks one request per cycle with round-robin fairness and drives the ALU from it. It captures `alu_result`/`zero` into a one-entry response register, tagged with the requester id, behind a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `CTRL_W`, 4, ALU control width

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req0_valid` in 1: requester 0 has an operation
- `req0_ready` out 1: requester 0 operation accepted this cycle
- `req0_a` in XLEN: requester 0 operand A
- `req0_b` in XLEN: requester 0 operand B
- `req0_ctrl` in CTRL_W: requester 0 ALU control code
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_ctrl`: same as requester 0, for requester 1
- `resp_valid` out 1: response register holds a result
- `resp_ready` in 1: consumer takes the response
- `resp_id` out 1: requester that issued the response (0/1)
- `resp_result` out XLEN: registered ALU result
- `resp_zero` out 1: registered zero flag
- `resp_illegal` out 1: control code was not a defined ALU op
- `alu_operand_a` out XLEN: to ALU `operand_a`
- `alu_operand_b` out XLEN: to ALU `operand_b`
- `alu_control` out CTRL_W: to ALU `alu_control`
- `alu_result` in XLEN: from ALU
- `alu_zero` in 1: from ALU `zero`

## Operation
- **Defined ALU codes:**
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - 1010–1111 are illegal.
- **Slot free:** `slot_free = !resp_valid || resp_ready`.
- **Grant:**
  - Only one valid: that requester is granted.
  - Both valid: the requester not in `last_grant` is granted.
  - Neither valid: no grant.
- **Ready:** `reqN_ready = grantN && slot_free`. At most one ready is high per cycle.
- **Transfer:** a transfer happens when `reqN_valid && reqN_ready`.
- **ALU drive:**
  - With a grant, the ALU ports carry the granted requester's `a`, `b`, `ctrl`, combinationally.
  - With no grant, the ALU ports carry a=0, b=0, ctrl=0000.
- **On transfer, at the clock edge:**
  - `resp_valid` ← 1, `resp_id` ← N, `last_grant` ← N.
  - Legal ctrl: `resp_result` ← `alu_result`, `resp_zero` ← `alu_zero`, `resp_illegal` ← 0.
  - Illegal ctrl: `resp_result` ← 0, `resp_zero` ← 0, `resp_illegal` ← 1. The code is still forwarded to the ALU, but its output is ignored.
- **Drain with no new transfer:** `resp_valid && resp_ready` with no transfer in the same cycle sets `resp_valid` ← 0. The other response fields hold their last values.
- **Stall:** `resp_valid && !resp_ready` means no transfer. All `resp_*` outputs hold stable, and `last_grant` holds.
- **Fairness:** with both requesters held valid and no stalls, grants alternate strictly. Neither requester waits more than one transfer.

## Timing
- **Reset (asynchronous, immediate on `rst_n`=0):**
  - `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_zero`=0, `resp_illegal`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Combinational outputs follow from this state: `req0_ready` equals `req0_valid` (the slot is free and requester 0 wins the tie); `req1_ready` is high only when `req1_valid` is high and `req0_valid` is low.
- **Reset during a pending response:** the response is discarded. No partial state survives.
- **Latency:** a request accepted in cycle N has `resp_valid`=1 in cycle N+1.
- **Throughput:** one operation per cycle while `resp_ready`=1. A drain and a new transfer in the same cycle are allowed, and the new result replaces the old one.
- **Combinational paths:** ready depends combinationally on both valids, `resp_valid` and `resp_ready`. Requesters must not derive valid from ready.
- **Request hold:** once valid, a requester holds `a`/`b`/`ctrl` stable until its transfer. The block does not check this.
- **Registers:** the only registered state is the response register plus `last_grant`. There is no other internal state.

## Test plan
- **Single request:** req0 ADD 15,10 with `resp_ready`=1 → `req0_ready`=1 same cycle; next cycle `resp_valid`=1, `resp_id`=0, `resp_result`=25, `resp_zero`=0.
- **Round-robin:** both valid for 4 cycles, req0 SUB 5,5 and req1 XOR F0F0F0F0,0F0F0F0F → grants go 0,1,0,1; responses go id0 result 0 zero 1, then id1 FFFFFFFF zero 0, alternating.
- **Backpressure:**
  - After one transfer, hold `resp_ready`=0 for 3 cycles → both readies 0 and `resp_*` stable.
  - Raise `resp_ready` → the held response drains and the pending request is accepted in the same cycle.
- **Illegal code:** req1 ctrl 1100 → `resp_illegal`=1, `resp_result`=0, `resp_zero`=0, `resp_id`=1.
- **SRA via requester 1:** req1 SRA 80000000,31 → `resp_result`=FFFFFFFF, `resp_illegal`=0.
- **Reset mid-operation:**
  - Drop `rst_n` while `resp_valid`=1 and stalled → `resp_valid`=0 immediately, without waiting for a clock edge.
  - After release, with both requesters valid → requester 0 is granted first.
